rv64_divider: RTL
=================

RV64_DIVIDER -- requirements
Module: rv64_divider

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width in bits.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when the block is idle.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_data  input  XLEN  dividend, from register-file ReadData1.
REQ-007 rs2_data  input  XLEN  divisor, from register-file ReadData2.
REQ-008 rd_in  input  5  destination register tag.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  single-cycle pulse marking result and rd_out valid.
REQ-011 result  output  XLEN  quotient or remainder, for register-file WriteData.
REQ-012 rd_out  output  5  destination tag of the completed operation.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1 at a clock edge ("edge 0"), the block SHALL latch op, rs1_data, rs2_data and rd_in, clear its 7-bit iteration counter and enter CALC.
REQ-015 Input changes after edge 0, including further start pulses, SHALL be ignored until the block returns to IDLE.
REQ-016 CALC SHALL perform one restoring-division step per edge on operand magnitudes, for exactly XLEN steps (edges 1..64), then enter FIX.
REQ-017 Magnitudes SHALL be two's-complement absolute values for DIV/REM and raw values for DIVU/REMU.
REQ-018 FIX (edge 65) SHALL load result and rd_out, assert done and enter DONE.
REQ-019 Signed quotient SHALL be negated iff the operand signs differ; signed remainder SHALL take the sign of the dividend.
REQ-020 Divisor zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return rs1_data unchanged.
REQ-021 Signed overflow (dividend 0x8000_0000_0000_0000, divisor all ones): DIV SHALL return the dividend; REM SHALL return 0.
REQ-022 Special cases SHALL keep the fixed latency, with the result overridden in FIX.
REQ-023 DONE SHALL last exactly one cycle; edge 66 SHALL return the FSM to IDLE and clear done.
REQ-024 The earliest following accept SHALL be at edge 67; start held high SHALL therefore yield one operation every 67 cycles.
REQ-025 result and rd_out SHALL hold their last values until the next FIX.

Reset
REQ-026 When reset=1 at an edge, the block SHALL set state to IDLE and clear busy, done, result, rd_out and all internal registers.
REQ-027 Reset SHALL take priority over start and over any state transition.
REQ-028 Reset during CALC, FIX or DONE SHALL abort the operation with no done pulse for it.
REQ-029 After reset deasserts, the block SHALL accept start on the first edge.

Verification
REQ-030 DIVU 100/7, rd_in=5 -> done high exactly 65 cycles after accept, result=14, rd_out=5; REMU on the same operands -> 2.
REQ-031 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; DIV 7/-2 -> 0xFFFF_FFFF_FFFF_FFFD.
REQ-032 DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 5/0 -> 5; latency unchanged at 65.
REQ-033 DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM on the same operands -> 0.
REQ-034 Reset 30 cycles into DIVU 100/7 -> busy=0 and result=0 next cycle, no done pulse; a new DIVU 9/3 then completes with result=3.
REQ-035 start with DIVU 50/5, then start pulses with 9/3 while busy -> single done with result=10; busy low for exactly one cycle before the next accept.

Source files
------------

// File: rtl/rv64_divider.sv
// rv64_divider: multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU.
// Fixed latency: accept at edge 0, XLEN iteration edges, sign/special-case
// fix-up at edge XLEN+1, done pulse for one cycle, back to idle one edge later.
module rv64_divider #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [6:0]      LAST_STEP = 7'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic [6:0]      cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;

  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            step_ok;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;
  logic            op_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] fix_val;

  // Operand magnitudes at accept: absolute value for signed ops, raw otherwise.
  always_comb begin
    a_mag_in = rs1_data;
    b_mag_in = rs2_data;
    if (!op[0] && rs1_data[XLEN-1]) a_mag_in = '0 - rs1_data;
    if (!op[0] && rs2_data[XLEN-1]) b_mag_in = '0 - rs2_data;
  end

  // One restoring step: shift next dividend bit into the partial remainder,
  // keep the subtraction only if it did not go negative.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, dvs};
    step_ok  = ~diff[XLEN];
    rem_next = step_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], step_ok};
  end

  // Final value: restore signs, then override divide-by-zero and overflow.
  always_comb begin
    op_signed = ~op_q[0];
    a_neg     = op_signed & a_q[XLEN-1];
    b_neg     = op_signed & b_q[XLEN-1];
    div_zero  = (b_q == '0);
    overflow  = op_signed & (a_q == MIN_NEG) & (b_q == '1);
    if (div_zero) begin
      fix_val = op_q[1] ? a_q : '1;
    end else if (overflow) begin
      fix_val = op_q[1] ? '0 : a_q;
    end else if (op_q[1]) begin
      fix_val = a_neg ? ('0 - rem) : rem;
    end else begin
      fix_val = (a_neg ^ b_neg) ? ('0 - quo) : quo;
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= rs1_data;
            b_q   <= rs2_data;
            rd_q  <= rd_in;
            quo   <= a_mag_in;
            rem   <= '0;
            dvs   <= b_mag_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 7'd1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          rd_out <= rd_q;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
